decode_sequencer: RTL and testbench

- Parametrised successor to the combinational instruction decoder.
- Buffers incoming 16-bit instructions in a small FIFO, decodes the head entry into registered fields, and drives register-file selects itself, one step per cycle.
- This removes the external nsel input that the datapath controller used to provide.
- Sits between instruction fetch (valid/ready producer) and the datapath register file/ALU.

---
 rtl/decode_sequencer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_decode_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_sequencer.sv
// Buffers 16-bit instructions in a FIFO, decodes the head entry, then drives register-file
// read/write strobes one step per cycle. DECODE_ILLEGAL_TRAP_EN makes an illegal instruction halt in TRAP.
module decode_sequencer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [2:0]        opcode,
    output logic [1:0]        op,
    output logic [1:0]        ALUop,
    output logic [1:0]        shift,
    output logic [2:0]        cond,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5,
    output logic [REG_AW-1:0] regnum,
    output logic              reg_re,
    output logic              reg_we,
    output logic [1:0]        step,
    output logic              done,
    output logic              illegal
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

`ifdef DECODE_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEQ = 2'd2, TRAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEQ = 2'd2} state_t;
`endif

    // Step entry is {read, write, reg[2:0]}; slot 3 stays empty so step+1 never indexes out of range.
    typedef struct packed {
        logic            ill;
        logic [1:0]      last;
        logic [3:0][4:0] ent;
    } plan_t;

    function automatic logic [4:0] rd_ent(input logic [2:0] r);
        return {2'b10, r};
    endfunction

    function automatic logic [4:0] wr_ent(input logic [2:0] r);
        return {2'b01, r};
    endfunction

    function automatic plan_t plan_decode(input logic [15:0] ins);
        plan_t      p;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [2:0] rm;
        p  = '0;
        rn = ins[10:8];
        rd = ins[7:5];
        rm = ins[2:0];
        case ({ins[15:13], ins[12:11]})
            5'b110_10: begin
                p.ent[0] = wr_ent(rn);
                p.last   = 2'd0;
            end
            5'b110_00, 5'b101_11: begin
                p.ent[0] = rd_ent(rm);
                p.ent[1] = wr_ent(rd);
                p.last   = 2'd1;
            end
            5'b101_00, 5'b101_10: begin
                p.ent[0] = rd_ent(rn);
                p.ent[1] = rd_ent(rm);
                p.ent[2] = wr_ent(rd);
                p.last   = 2'd2;
            end
            5'b101_01: begin
                p.ent[0] = rd_ent(rn);
                p.ent[1] = rd_ent(rm);
                p.last   = 2'd1;
            end
            default: begin
                p.ill  = 1'b1;
                p.last = 2'd0;
            end
        endcase
        return p;
    endfunction

    state_t              state_q, state_d;
    logic [15:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    plan_t               plan_q, plan_d;
    logic [2:0]          opcode_q, opcode_d;
    logic [1:0]          op_q, op_d;
    logic [1:0]          shift_q, shift_d;
    logic [2:0]          cond_q, cond_d;
    logic [DATA_W-1:0]   sximm8_q, sximm8_d;
    logic [DATA_W-1:0]   sximm5_q, sximm5_d;
    logic [REG_AW-1:0]   regnum_q, regnum_d;
    logic                reg_re_q, reg_re_d;
    logic                reg_we_q, reg_we_d;
    logic [1:0]          step_q, step_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;

    logic                push_s;
    logic                pop_s;
    logic [15:0]         head_s;
    plan_t               head_plan_s;
    plan_t               src_plan_s;
    logic [1:0]          src_idx_s;
    logic [4:0]          src_ent_s;

    assign in_ready = (count_q != FULL_CNT);
    assign opcode   = opcode_q;
    assign op       = op_q;
    assign ALUop    = op_q;
    assign shift    = shift_q;
    assign cond     = cond_q;
    assign sximm8   = sximm8_q;
    assign sximm5   = sximm5_q;
    assign regnum   = regnum_q;
    assign reg_re   = reg_re_q;
    assign reg_we   = reg_we_q;
    assign step     = step_q;
    assign done     = done_q;
    assign illegal  = illegal_q;

    // FIFO bookkeeping, decode of the head entry and sequencer next-state.
    always_comb begin
        push_s      = in_valid && in_ready;
        pop_s       = (state_q == LOAD);
        head_s      = mem_q[rd_ptr_q];
        head_plan_s = plan_decode(head_s);

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

        // Outputs are registered, so the d-side presents the step that the next cycle shows.
        if (state_q == LOAD) begin
            src_plan_s = head_plan_s;
            src_idx_s  = 2'd0;
        end else begin
            src_plan_s = plan_q;
            src_idx_s  = step_q + 2'd1;
        end
        src_ent_s = src_plan_s.ent[src_idx_s];

        state_d   = state_q;
        plan_d    = plan_q;
        opcode_d  = opcode_q;
        op_d      = op_q;
        shift_d   = shift_q;
        cond_d    = cond_q;
        sximm8_d  = sximm8_q;
        sximm5_d  = sximm5_q;
        regnum_d  = '0;
        reg_re_d  = 1'b0;
        reg_we_d  = 1'b0;
        step_d    = 2'd0;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                opcode_d  = head_s[15:13];
                op_d      = head_s[12:11];
                shift_d   = head_s[4:3];
                cond_d    = head_s[10:8];
                sximm8_d  = DATA_W'($signed(head_s[7:0]));
                sximm5_d  = DATA_W'($signed(head_s[4:0]));
                plan_d    = head_plan_s;
                state_d   = SEQ;
                regnum_d  = REG_AW'(src_ent_s[2:0]);
                reg_re_d  = src_ent_s[4];
                reg_we_d  = src_ent_s[3];
                step_d    = src_idx_s;
                done_d    = (src_idx_s == src_plan_s.last);
                illegal_d = src_plan_s.ill;
            end
            SEQ: begin
                if (step_q == plan_q.last) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                    if (plan_q.ill) begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end else if (count_d != '0) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    if (count_d != '0) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end else begin
                    regnum_d  = REG_AW'(src_ent_s[2:0]);
                    reg_re_d  = src_ent_s[4];
                    reg_we_d  = src_ent_s[3];
                    step_d    = src_idx_s;
                    done_d    = (src_idx_s == src_plan_s.last);
                    illegal_d = src_plan_s.ill;
                end
            end
`ifdef DECODE_ILLEGAL_TRAP_EN
            TRAP: begin
                state_d   = TRAP;
                illegal_d = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO storage; stale contents are harmless because the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= instr_in;
        end
    end

    // State, pointers, decoded fields and output strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            plan_q    <= '0;
            opcode_q  <= 3'd0;
            op_q      <= 2'd0;
            shift_q   <= 2'd0;
            cond_q    <= 3'd0;
            sximm8_q  <= '0;
            sximm5_q  <= '0;
            regnum_q  <= '0;
            reg_re_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            step_q    <= 2'd0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            plan_q    <= plan_d;
            opcode_q  <= opcode_d;
            op_q      <= op_d;
            shift_q   <= shift_d;
            cond_q    <= cond_d;
            sximm8_q  <= sximm8_d;
            sximm5_q  <= sximm5_d;
            regnum_q  <= regnum_d;
            reg_re_q  <= reg_re_d;
            reg_we_q  <= reg_we_d;
            step_q    <= step_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// Self-checking bench for decode_sequencer: directed scenarios plus random instruction
// streams checked against a queue of expected register steps built from the ISA rules.
module tb_decode_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr_in;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [2:0]  cond;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [2:0]  regnum;
    logic        reg_re;
    logic        reg_we;
    logic [1:0]  step;
    logic        done;
    logic        illegal;

    always #5 clk = ~clk;

    decode_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .instr_in (instr_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .op       (op),
        .ALUop    (ALUop),
        .shift    (shift),
        .cond     (cond),
        .sximm8   (sximm8),
        .sximm5   (sximm5),
        .regnum   (regnum),
        .reg_re   (reg_re),
        .reg_we   (reg_we),
        .step     (step),
        .done     (done),
        .illegal  (illegal)
    );

    typedef struct packed {
        logic [15:0] ins;
        logic        re;
        logic        we;
        logic [2:0]  rg;
        logic [1:0]  st;
        logic        dn;
        logic        il;
    } step_t;

    step_t exp_q[$];
    step_t mon_e;
    int    n_vec = 0;
    int    n_err = 0;
    logic  trapped = 1'b0;
    logic  prev_active = 1'b0;
    logic  cur_active;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sext(input int v, input int bits);
        int s;
        s = (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
        return 16'(s);
    endfunction

    // kind: 0 = no strobe (illegal), 1 = read, 2 = write
    function automatic void model_push(input logic [15:0] w);
        int    opc, opv, rn, rd, rm;
        int    kinds[$];
        int    regs[$];
        bit    bad;
        step_t e;
        opc = int'(w[15:13]);
        opv = int'(w[12:11]);
        rn  = int'(w[10:8]);
        rd  = int'(w[7:5]);
        rm  = int'(w[2:0]);
        bad = 1'b0;
        if (opc == 6 && opv == 2) begin
            kinds.push_back(2); regs.push_back(rn);
        end else if ((opc == 6 && opv == 0) || (opc == 5 && opv == 3)) begin
            kinds.push_back(1); regs.push_back(rm);
            kinds.push_back(2); regs.push_back(rd);
        end else if (opc == 5 && (opv == 0 || opv == 2)) begin
            kinds.push_back(1); regs.push_back(rn);
            kinds.push_back(1); regs.push_back(rm);
            kinds.push_back(2); regs.push_back(rd);
        end else if (opc == 5 && opv == 1) begin
            kinds.push_back(1); regs.push_back(rn);
            kinds.push_back(1); regs.push_back(rm);
        end else begin
            bad = 1'b1;
            kinds.push_back(0); regs.push_back(0);
        end
        for (int i = 0; i < kinds.size(); i++) begin
            e.ins = w;
            e.re  = (kinds[i] == 1);
            e.we  = (kinds[i] == 2);
            e.rg  = 3'(regs[i]);
            e.st  = 2'(i);
            e.dn  = (i == kinds.size() - 1);
            e.il  = bad;
            exp_q.push_back(e);
        end
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (bad) trapped = 1'b1;
`endif
    endfunction

    // Model side: record accepted pushes, flush on reset.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            trapped = 1'b0;
        end else if (in_valid && in_ready && !trapped) begin
            model_push(instr_in);
        end
    end

    // Observe every cycle; each strobe or done cycle must be the next expected step.
    always @(negedge clk) begin
        if (reset) begin
            prev_active = 1'b0;
        end else begin
            cur_active = reg_re || reg_we || done;
            check_eq("strobe_excl", 32'(reg_re && reg_we), 32'd0);
            if (cur_active) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_step", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("reg_re", 32'(reg_re), 32'(mon_e.re));
                    check_eq("reg_we", 32'(reg_we), 32'(mon_e.we));
                    check_eq("regnum", 32'(regnum), 32'(mon_e.rg));
                    check_eq("step", 32'(step), 32'(mon_e.st));
                    check_eq("done", 32'(done), 32'(mon_e.dn));
                    check_eq("illegal", 32'(illegal), 32'(mon_e.il));
                    check_eq("opcode", 32'(opcode), 32'(mon_e.ins[15:13]));
                    check_eq("op", 32'(op), 32'(mon_e.ins[12:11]));
                    check_eq("ALUop", 32'(ALUop), 32'(mon_e.ins[12:11]));
                    check_eq("shift", 32'(shift), 32'(mon_e.ins[4:3]));
                    check_eq("cond", 32'(cond), 32'(mon_e.ins[10:8]));
                    check_eq("sximm8", 32'(sximm8), 32'(sext(int'(mon_e.ins[7:0]), 8)));
                    check_eq("sximm5", 32'(sximm5), 32'(sext(int'(mon_e.ins[4:0]), 5)));
                    if (mon_e.st != 2'd0) check_eq("step_gap", 32'(prev_active), 32'd1);
                end
            end else if (exp_q.size() != 0 && exp_q[0].st != 2'd0) begin
                check_eq("mid_stall", 32'(cur_active), 32'd1);
            end
            prev_active = cur_active;
        end
    end

    task automatic push_instr(input logic [15:0] w);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        instr_in = w;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check_eq("push_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_active(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!(reg_re || reg_we || done) && lat < 50);
        if (!(reg_re || reg_we || done)) check_eq("wait_active_timeout", 32'(lat), 32'd0);
    endtask

    task automatic drain();
        int g;
        g = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        int          k;
        w = 16'($urandom);
`ifdef DECODE_ILLEGAL_TRAP_EN
        k = $urandom_range(0, 5);
`else
        k = $urandom_range(0, 7);
`endif
        case (k)
            0: w[15:11] = 5'b11010;
            1: w[15:11] = 5'b11000;
            2: w[15:11] = 5'b10100;
            3: w[15:11] = 5'b10110;
            4: w[15:11] = 5'b10101;
            5: w[15:11] = 5'b10111;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        int lat;
        reset    = 1'b1;
        in_valid = 1'b0;
        instr_in = 16'h0000;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_regnum", 32'(regnum), 32'd0);
        check_eq("rst_reg_re", 32'(reg_re), 32'd0);
        check_eq("rst_reg_we", 32'(reg_we), 32'd0);
        check_eq("rst_step", 32'(step), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_illegal", 32'(illegal), 32'd0);
        check_eq("rst_opcode", 32'(opcode), 32'd0);
        check_eq("rst_sximm8", 32'(sximm8), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // MOV R2,#-11
        push_instr(16'hD2F5);
        wait_active(lat);
        check_eq("mov_latency", 32'(lat), 32'd3);
        check_eq("mov_sximm8", 32'(sximm8), 32'hFFF5);
        check_eq("mov_cond", 32'(cond), 32'd2);
        check_eq("mov_regnum", 32'(regnum), 32'd2);
        check_eq("mov_we", 32'(reg_we), 32'd1);
        check_eq("mov_done", 32'(done), 32'd1);

        // ADD R3,R1,R4
        push_instr(16'hA164);
        wait_active(lat);
        check_eq("add_s0_reg", 32'(regnum), 32'd1);
        check_eq("add_s0_re", 32'(reg_re), 32'd1);
        check_eq("add_shift", 32'(shift), 32'd0);
        @(negedge clk);
        check_eq("add_s1_reg", 32'(regnum), 32'd4);
        check_eq("add_s1_re", 32'(reg_re), 32'd1);
        @(negedge clk);
        check_eq("add_s2_reg", 32'(regnum), 32'd3);
        check_eq("add_s2_we", 32'(reg_we), 32'd1);
        check_eq("add_s2_done", 32'(done), 32'd1);

        // CMP R1,R0
        push_instr(16'hA920);
        wait_active(lat);
        check_eq("cmp_s0_reg", 32'(regnum), 32'd1);
        @(negedge clk);
        check_eq("cmp_s1_reg", 32'(regnum), 32'd0);
        check_eq("cmp_s1_re", 32'(reg_re), 32'd1);
        check_eq("cmp_s1_we", 32'(reg_we), 32'd0);
        check_eq("cmp_s1_done", 32'(done), 32'd1);
        drain();

        // Back-pressure with in_valid held high
        push_instr(16'hA164);
        push_instr(16'hA920);
        @(negedge clk);
        check_eq("fill_in_ready", 32'(in_ready), 32'd0);
        push_instr(16'hD2F5);
        push_instr(16'hC0E3);
        push_instr(16'hB86A);
        drain();

        // Reset on step 1 of an ADD with another entry queued
        push_instr(16'hA164);
        push_instr(16'hD2F5);
        wait_active(lat);
        @(negedge clk);
        check_eq("abort_step1", 32'(step), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_re", 32'(reg_re), 32'd0);
        check_eq("abort_we", 32'(reg_we), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_step", 32'(step), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("abort_flushed", 32'(exp_q.size()), 32'd0);

        // Random stream with random gaps
        for (int i = 0; i < 250; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            push_instr(rand_instr());
        end
        drain();

        // Undecodable instruction
        push_instr(16'h0000);
        wait_active(lat);
        check_eq("ill_illegal", 32'(illegal), 32'd1);
        check_eq("ill_done", 32'(done), 32'd1);
        check_eq("ill_re", 32'(reg_re), 32'd0);
        check_eq("ill_we", 32'(reg_we), 32'd0);
        @(negedge clk);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check_eq("trap_sticky", 32'(illegal), 32'd1);
        push_instr(16'hD2F5);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("trap_sticky_late", 32'(illegal), 32'd1);
        check_eq("trap_no_we", 32'(reg_we), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`else
        check_eq("ill_pulse", 32'(illegal), 32'd0);
        push_instr(16'hD2F5);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
